// File: rtl/loader_pkg.sv
// Shared types for the burst loader: the FSM state encoding.
package loader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/latency_pipe.sv
// Delay line of {valid, tag} pairs matching the memory read latency.
module latency_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/mem_burst_loader.sv
// Copies len_eff words from a synchronous-read memory into a register array,
// mirroring each captured word on a stream tap.
module mem_burst_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned MAX_WORDS    = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned IDX_W        = $clog2(MAX_WORDS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [ADDR_WIDTH-1:0]           base_addr_i,
    input  logic [IDX_W-1:0]                length_i,
    output logic                            mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
    output logic [MAX_WORDS*DATA_WIDTH-1:0] data_arr_o,
    output logic                            word_valid_o,
    output logic [IDX_W-1:0]                word_idx_o,
    output logic [DATA_WIDTH-1:0]           word_data_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            len_err_o
);

    localparam logic [IDX_W-1:0] MaxLen = IDX_W'(MAX_WORDS);

    loader_state_t state_q, state_d;

    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]      len_q, len_d;
    logic                  len_err_q, len_err_d;
    logic                  wv_q, wv_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] arr_q [MAX_WORDS];
    logic [DATA_WIDTH-1:0] arr_d [MAX_WORDS];

    logic             pipe_vld;
    logic [IDX_W-1:0] pipe_idx;
    logic [IDX_W-1:0] len_eff;
    logic             running, accept, aborting, last_issue, cap, last_cap;

    assign len_eff    = (length_i > MaxLen) ? MaxLen : length_i;
    assign running    = (state_q == StFetch) || (state_q == StDrain);
    assign accept     = !running && start_i;
    assign aborting   = running && abort_i;
    assign last_issue = (state_q == StFetch) && (rd_idx_q == len_q - IDX_W'(1));
    // An abort edge must not capture the word emerging in that same cycle.
    assign cap        = pipe_vld && !aborting;
    assign last_cap   = cap && (pipe_idx == len_q - IDX_W'(1));

    latency_pipe #(
        .DEPTH (READ_LATENCY),
        .W     (IDX_W)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .flush_i (aborting),
        .valid_i (rd_en_q),
        .data_i  (rd_idx_q),
        .valid_o (pipe_vld),
        .data_o  (pipe_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = (len_eff == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (aborting) begin
                    state_d = StIdle;
                end else if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (aborting) begin
                    state_d = StIdle;
                end else if (last_cap) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = running;
        done_o = (state_q == StDone);
    end

    always_comb begin
        rd_en_d   = rd_en_q;
        addr_d    = addr_q;
        rd_idx_d  = rd_idx_q;
        len_d     = len_q;
        len_err_d = len_err_q;
        wv_d      = cap;
        widx_d    = cap ? pipe_idx : widx_q;
        wdata_d   = cap ? mem_rdata_i : wdata_q;
        arr_d     = arr_q;
        if (accept) begin
            len_d     = len_eff;
            len_err_d = (length_i > MaxLen);
            rd_idx_d  = '0;
            rd_en_d   = (len_eff != '0);
            // The address holds across an empty run.
            if (len_eff != '0) begin
                addr_d = base_addr_i;
            end
            for (int i = 0; i < int'(MAX_WORDS); i++) begin
                arr_d[i] = '0;
            end
        end else if (aborting) begin
            rd_en_d = 1'b0;
        end else begin
            if (state_q == StFetch) begin
                if (last_issue) begin
                    rd_en_d = 1'b0;
                end else begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            if (cap) begin
                for (int i = 0; i < int'(MAX_WORDS); i++) begin
                    if (pipe_idx == IDX_W'(i)) begin
                        arr_d[i] = mem_rdata_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            rd_idx_q  <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
            wv_q      <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < int'(MAX_WORDS); i++) begin
                arr_q[i] <= '0;
            end
        end else begin
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            rd_idx_q  <= rd_idx_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
            wv_q      <= wv_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            arr_q     <= arr_d;
        end
    end

    for (genvar g = 0; g < int'(MAX_WORDS); g++) begin : g_pack
        assign data_arr_o[g*DATA_WIDTH +: DATA_WIDTH] = arr_q[g];
    end

    assign mem_rd_en_o  = rd_en_q;
    assign mem_addr_o   = addr_q;
    assign word_valid_o = wv_q;
    assign word_idx_o   = widx_q;
    assign word_data_o  = wdata_q;
    assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_mem_burst_loader.sv
// Randomised bench for mem_burst_loader against a cycle-formula reference model.
module tb_mem_burst_loader;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int MAXW = 32;
    localparam int LAT  = 2;
    localparam int IW   = $clog2(MAXW + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [AW-1:0]     base_addr_i = '0;
    logic [IW-1:0]     length_i = '0;
    logic              mem_rd_en_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_rdata_i;
    logic [MAXW*DW-1:0] data_arr_o;
    logic              word_valid_o;
    logic [IW-1:0]     word_idx_o;
    logic [DW-1:0]     word_data_o;
    logic              busy_o, done_o, len_err_o;

    mem_burst_loader #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MAX_WORDS    (MAXW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .base_addr_i  (base_addr_i),
        .length_i     (length_i),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .data_arr_o   (data_arr_o),
        .word_valid_o (word_valid_o),
        .word_idx_o   (word_idx_o),
        .word_data_o  (word_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .len_err_o    (len_err_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM with LAT cycles of latency.
    logic [DW-1:0] rom    [256];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= rom[mem_addr_o];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata_i = rd_pipe[LAT-1];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_rd = 0;
    int n_wv = 0;
    bit chk_en = 1'b0;

    // Reference model: a run is described by its start cycle, length, base and abort cycle.
    bit            m_active = 1'b0;
    int            m_t0, m_len, m_da;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_addr_prev = '0;
    bit            m_len_err = 1'b0;
    logic [DW-1:0] m_rom [256];

    typedef struct {
        bit              rd_en;
        logic [AW-1:0]   addr;
        bit              wv;
        int              idx;
        logic [DW-1:0]   wdata;
        bit              busy;
        bit              done;
        bit              len_err;
        logic [MAXW*DW-1:0] arr;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        int d, k, lim, last;
        bit ab;
        logic [AW-1:0] a;
        e.rd_en = 0; e.addr = m_addr_prev; e.wv = 0; e.idx = 0; e.wdata = '0;
        e.busy = 0; e.done = 0; e.len_err = m_len_err; e.arr = '0;
        if (!m_active) return e;
        d  = cyc - m_t0;
        ab = (m_da >= 0) && (d > m_da);
        if (!ab && d >= 1 && d <= m_len) begin
            e.rd_en = 1;
            e.addr  = m_base + AW'(d - 1);
        end else if (m_len > 0) begin
            last   = (ab && m_da < m_len) ? m_da : m_len;
            e.addr = m_base + AW'(last - 1);
        end
        if (!ab) begin
            k = d - 2 - LAT;
            if (k >= 0 && k < m_len) begin
                e.wv    = 1;
                e.idx   = k;
                a       = m_base + AW'(k);
                e.wdata = m_rom[a];
            end
            if (m_len == 0) e.done = 1;
            else begin
                e.done = (d >= m_len + LAT + 1);
                e.busy = !e.done;
            end
        end
        lim = ab ? m_da : d;
        for (int j = 0; j < m_len; j++) begin
            if (j + 2 + LAT <= lim) begin
                a = m_base + AW'(j);
                e.arr[j*DW +: DW] = m_rom[a];
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model update at each active edge, using the inputs sampled there.
    initial forever begin
        exp_t cur;
        @(posedge clk);
        cur = expect_now();
        if (reset) begin
            m_active = 0; m_len_err = 0; m_addr_prev = '0;
        end else if (start_i && !cur.busy) begin
            m_addr_prev = cur.addr;
            m_active    = 1;
            m_t0        = cyc;
            m_base      = base_addr_i;
            m_len       = (int'(length_i) > MAXW) ? MAXW : int'(length_i);
            m_len_err   = (int'(length_i) > MAXW);
            m_da        = -1;
            m_rom       = rom;
        end else if (abort_i && cur.busy) begin
            m_da = cyc - m_t0;
        end
        cyc++;
    end

    // Compare on the falling edge, every cycle once reset has been applied.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (mem_rd_en_o) n_rd++;
        if (word_valid_o) n_wv++;
        if (chk_en) begin
            e = expect_now();
            chk("rd_en", 256'(mem_rd_en_o), 256'(e.rd_en));
            chk("mem_addr", 256'(mem_addr_o), 256'(e.addr));
            chk("word_valid", 256'(word_valid_o), 256'(e.wv));
            if (e.wv) begin
                chk("word_idx", 256'(word_idx_o), 256'(e.idx));
                chk("word_data", 256'(word_data_o), 256'(e.wdata));
            end
            chk("busy", 256'(busy_o), 256'(e.busy));
            chk("done", 256'(done_o), 256'(e.done));
            chk("len_err", 256'(len_err_o), 256'(e.len_err));
            chk("data_arr", 256'(data_arr_o), 256'(e.arr));
            chk("busy_done_excl", 256'(busy_o & done_o), 256'(0));
        end
    end

    // Leaves the caller #1 into cycle t+1, where t is the cycle start was sampled in.
    task automatic pulse_start(input logic [AW-1:0] b, input int len, input bit with_abort);
        @(posedge clk); #1;
        start_i = 1; abort_i = with_abort; base_addr_i = b; length_i = IW'(len);
        n_rd = 0; n_wv = 0;
        @(posedge clk); #1;
        start_i = 0; abort_i = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done_o && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_timeout", 256'(done_o), 256'(1));
    endtask

    initial begin
        int lat;
        for (int a = 0; a < 256; a++) rom[a] = DW'(a) ^ 8'h5A;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        chk("reset_done", 256'(done_o), 256'(0));
        chk("reset_arr", 256'(data_arr_o), 256'(0));

        // Full 32-word load from base 0.
        pulse_start(8'h00, 32, 0);
        wait_done(lat);
        chk("full_done_lat", 256'(lat), 256'(35));
        repeat (2) @(posedge clk); #1;
        chk("full_nrd", 256'(n_rd), 256'(32));
        chk("full_nwv", 256'(n_wv), 256'(32));
        for (int k = 0; k < MAXW; k++)
            chk("full_word", 256'(data_arr_o[k*DW +: DW]), 256'(DW'(k) ^ 8'h5A));

        // Address wrap.
        pulse_start(8'hFE, 4, 0);
        wait_done(lat);
        chk("wrap_done_lat", 256'(lat), 256'(7));
        chk("wrap_w0", 256'(data_arr_o[7:0]), 256'(8'hA4));
        chk("wrap_w1", 256'(data_arr_o[15:8]), 256'(8'hA5));
        chk("wrap_w2", 256'(data_arr_o[23:16]), 256'(8'h5A));
        chk("wrap_w3", 256'(data_arr_o[31:24]), 256'(8'h5B));
        chk("wrap_tail", 256'(data_arr_o[MAXW*DW-1:32]), 256'(0));

        // Over-length request is clamped and flagged.
        pulse_start(8'h10, 40, 0);
        wait_done(lat);
        chk("ovf_done_lat", 256'(lat), 256'(35));
        chk("ovf_len_err", 256'(len_err_o), 256'(1));
        chk("ovf_nrd", 256'(n_rd), 256'(32));

        // Empty run, with abort held alongside start (start wins).
        pulse_start(8'h33, 0, 1);
        wait_done(lat);
        chk("zero_done_lat", 256'(lat), 256'(1));
        repeat (3) @(posedge clk); #1;
        chk("zero_nrd", 256'(n_rd), 256'(0));
        chk("zero_arr", 256'(data_arr_o), 256'(0));
        chk("zero_len_err", 256'(len_err_o), 256'(0));

        // Abort sampled at the end of cycle t+5.
        pulse_start(8'h00, 32, 0);
        repeat (4) @(posedge clk); #1;
        abort_i = 1;
        @(posedge clk); #1;
        abort_i = 0;
        chk("abort_busy", 256'(busy_o), 256'(0));
        repeat (5) @(posedge clk); #1;
        chk("abort_nwv", 256'(n_wv), 256'(2));
        chk("abort_done", 256'(done_o), 256'(0));
        chk("abort_w0", 256'(data_arr_o[7:0]), 256'(8'h5A));
        chk("abort_w1", 256'(data_arr_o[15:8]), 256'(8'h5B));
        chk("abort_tail", 256'(data_arr_o[MAXW*DW-1:16]), 256'(0));
        abort_i = 1;
        @(posedge clk); #1;
        abort_i = 0;

        // Mid-FETCH start is ignored; reset lands in DRAIN.
        pulse_start(8'h80, 8, 0);
        repeat (2) @(posedge clk); #1;
        start_i = 1; base_addr_i = 8'h00; length_i = IW'(3);
        @(posedge clk); #1;
        start_i = 0;
        repeat (4) @(posedge clk); #1;
        chk("ign_addr", 256'(mem_addr_o), 256'(8'h87));
        @(posedge clk); #1;
        chk("drain_busy", 256'(busy_o), 256'(1));
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_arr", 256'(data_arr_o), 256'(0));

        // Random runs with stray starts/aborts and wandering base/length inputs.
        for (int it = 0; it < 20; it++) begin
            int nc, guard;
            for (int a = 0; a < 256; a++) rom[a] = DW'($urandom);
            pulse_start(AW'($urandom), $urandom_range(0, 36), bit'($urandom_range(0, 1)));
            nc = $urandom_range(5, 45);
            for (int c = 0; c < nc; c++) begin
                abort_i     = ($urandom_range(0, 39) == 0);
                start_i     = ($urandom_range(0, 29) == 0);
                base_addr_i = AW'($urandom);
                length_i    = IW'($urandom_range(0, 36));
                @(posedge clk); #1;
            end
            start_i = 0; abort_i = 0;
            guard = 0;
            while (busy_o && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("rand_settle", 256'(busy_o), 256'(0));
            repeat (2) @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
